// File: rtl/sensor_conditioner.sv
`timescale 1ns/1ps
// Vehicle-sensor conditioner: two-flop sync, debounce FSM and stuck-on detection per road.
// Define SENSOR_LATCH_EN to hold demand until the light controller strobes clr_a/clr_b.
module sensor_channel #(
    parameter int DB_LEN    = 3,
    parameter int STUCK_LEN = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    input  logic clr,
    output logic s,
    output logic fault
);
    typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} state_t;

    localparam logic [7:0]  DB_LIM    = 8'(DB_LEN);
    localparam logic [15:0] STUCK_LIM = 16'(STUCK_LEN);

    logic        sync_p0, sync_p1;
    state_t      state, state_nxt;
    logic [7:0]  db_cnt, db_cnt_nxt;
    logic [15:0] stuck_cnt, stuck_nxt;
    logic        deb, deb_nxt, fault_nxt, s_nxt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v >= STUCK_LIM) ? STUCK_LIM : v + 16'd1;
    endfunction

    always_comb begin
        state_nxt  = state;
        db_cnt_nxt = db_cnt;
        if (tick) begin
            case (state)
                STABLE_LO: if (sync_p1) begin
                    if (DB_LIM == 8'd1) begin
                        state_nxt  = STABLE_HI;
                        db_cnt_nxt = 8'd0;
                    end else begin
                        state_nxt  = CHK_HI;
                        db_cnt_nxt = 8'd1;
                    end
                end
                CHK_HI: if (sync_p1) begin
                    if (db_cnt + 8'd1 >= DB_LIM) begin
                        state_nxt  = STABLE_HI;
                        db_cnt_nxt = 8'd0;
                    end else begin
                        db_cnt_nxt = db_cnt + 8'd1;
                    end
                end else begin
                    state_nxt  = STABLE_LO;
                    db_cnt_nxt = 8'd0;
                end
                STABLE_HI: if (!sync_p1) begin
                    if (DB_LIM == 8'd1) begin
                        state_nxt  = STABLE_LO;
                        db_cnt_nxt = 8'd0;
                    end else begin
                        state_nxt  = CHK_LO;
                        db_cnt_nxt = 8'd1;
                    end
                end
                CHK_LO: if (!sync_p1) begin
                    if (db_cnt + 8'd1 >= DB_LIM) begin
                        state_nxt  = STABLE_LO;
                        db_cnt_nxt = 8'd0;
                    end else begin
                        db_cnt_nxt = db_cnt + 8'd1;
                    end
                end else begin
                    state_nxt  = STABLE_HI;
                    db_cnt_nxt = 8'd0;
                end
                default: begin
                    state_nxt  = STABLE_LO;
                    db_cnt_nxt = 8'd0;
                end
            endcase
        end
    end

    assign deb     = (state == STABLE_HI) || (state == CHK_LO);
    assign deb_nxt = (state_nxt == STABLE_HI) || (state_nxt == CHK_LO);

    // Stuck count follows the level already debounced; fault is sticky until reset.
    assign stuck_nxt = !deb ? 16'd0 : (tick ? sat_inc(stuck_cnt) : stuck_cnt);
    assign fault_nxt = fault | (stuck_nxt == STUCK_LIM);

`ifdef SENSOR_LATCH_EN
    logic dem, dem_nxt;
    assign dem_nxt = (deb_nxt & ~deb) ? 1'b1 : (clr ? 1'b0 : dem);
    assign s_nxt   = dem_nxt | fault_nxt;
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign s_nxt      = deb_nxt | fault_nxt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0   <= 1'b0;
            sync_p1   <= 1'b0;
            state     <= STABLE_LO;
            db_cnt    <= 8'd0;
            stuck_cnt <= 16'd0;
            fault     <= 1'b0;
            s         <= 1'b0;
`ifdef SENSOR_LATCH_EN
            dem       <= 1'b0;
`endif
        end else begin
            sync_p0   <= raw;
            sync_p1   <= sync_p0;
            state     <= state_nxt;
            db_cnt    <= db_cnt_nxt;
            stuck_cnt <= stuck_nxt;
            fault     <= fault_nxt;
            s         <= s_nxt;
`ifdef SENSOR_LATCH_EN
            dem       <= dem_nxt;
`endif
        end
    end
endmodule

module sensor_conditioner #(
    parameter int DB_LEN    = 3,
    parameter int STUCK_LEN = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw_a,
    input  logic raw_b,
    input  logic clr_a,
    input  logic clr_b,
    output logic Sa,
    output logic Sb,
    output logic fault_a,
    output logic fault_b
);
    sensor_channel #(.DB_LEN(DB_LEN), .STUCK_LEN(STUCK_LEN)) u_chan_a (
        .clk(clk), .reset(reset), .tick(tick), .raw(raw_a), .clr(clr_a),
        .s(Sa), .fault(fault_a)
    );

    sensor_channel #(.DB_LEN(DB_LEN), .STUCK_LEN(STUCK_LEN)) u_chan_b (
        .clk(clk), .reset(reset), .tick(tick), .raw(raw_b), .clr(clr_b),
        .s(Sb), .fault(fault_b)
    );
endmodule

// File: tb/tb_sensor_conditioner.sv
`timescale 1ns/1ps
// Scoreboard bench for sensor_conditioner: expected {fault_b,fault_a,Sb,Sa} vectors are queued per cycle.
module tb_sensor_conditioner;
    localparam int DB_LEN    = 3;
    localparam int STUCK_LEN = 5;
`ifdef SENSOR_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b1, tick = 1'b0;
    logic raw_a = 1'b0, raw_b = 1'b0, clr_a = 1'b0, clr_b = 1'b0;
    logic Sa, Sb, fault_a, fault_b;

    sensor_conditioner #(.DB_LEN(DB_LEN), .STUCK_LEN(STUCK_LEN)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .raw_a(raw_a), .raw_b(raw_b), .clr_a(clr_a), .clr_b(clr_b),
        .Sa(Sa), .Sb(Sb), .fault_a(fault_a), .fault_b(fault_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] exp;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_now(input string name, input logic [3:0] exp);
        exp_t e;
        e.cyc  = cyc;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endtask

    // One tick strobe, then three idle clocks; output checked right after the tick and late in the gap.
    task automatic tick_chk(input string name, input logic [3:0] exp);
        tick = 1'b1;
        step();
        tick = 1'b0;
        expect_now(name, exp);
        step(2);
        expect_now({name, "_hold"}, exp);
        step();
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            n_checks++;
            if (mon_e.cyc != cyc)
                $display("FAIL %s: check missed, due cycle %0d seen at %0d", mon_e.name, mon_e.cyc, cyc);
            else if ({fault_b, fault_a, Sb, Sa} !== mon_e.exp)
                $display("FAIL %s: {fault_b,fault_a,Sb,Sa} got %b required %b",
                         mon_e.name, {fault_b, fault_a, Sb, Sa}, mon_e.exp);
            else
                n_pass++;
        end
    end

    initial begin
        step(2);
        expect_now("reset", 4'b0000);
        reset = 1'b0;
        step();

        // Road A: debounce, then stuck-on fault after five more high ticks
        raw_a = 1'b1;
        step(2);
        tick_chk("a_t1", 4'b0000);
        tick_chk("a_t2", 4'b0000);
        tick_chk("a_t3", 4'b0001);
        for (int i = 4; i <= 7; i++) tick_chk("a_stuck", 4'b0001);
        tick_chk("a_fault", 4'b0101);
        raw_a = 1'b0;
        step(2);
        tick_chk("a_fall1", 4'b0101);
        tick_chk("a_fall2", 4'b0101);
        tick_chk("a_fall3", 4'b0101);
        reset = 1'b1;
        expect_now("rst_async", 4'b0000);
        step();
        reset = 1'b0;
        expect_now("rst_rel", 4'b0000);
        step();

        // Road B: two-tick glitch rejected, then a real pulse
        raw_b = 1'b1;
        step(2);
        tick_chk("b_g1", 4'b0000);
        tick_chk("b_g2", 4'b0000);
        raw_b = 1'b0;
        step(2);
        tick_chk("b_g3", 4'b0000);
        raw_b = 1'b1;
        step(2);
        tick_chk("b_r1", 4'b0000);
        tick_chk("b_r2", 4'b0000);
        tick_chk("b_r3", 4'b0010);
        raw_b = 1'b0;
        step(2);
        tick_chk("b_f1", 4'b0010);
        tick_chk("b_f2", 4'b0010);
        tick_chk("b_f3", LATCH ? 4'b0010 : 4'b0000);
        clr_b = 1'b1;
        step();
        clr_b = 1'b0;
        expect_now("b_clr", 4'b0000);
        step(3);

        // Reset in the middle of a debounce discards progress
        raw_a = 1'b1;
        step(2);
        tick_chk("p_t1", 4'b0000);
        tick_chk("p_t2", 4'b0000);
        reset = 1'b1;
        expect_now("rst_mid", 4'b0000);
        step();
        reset = 1'b0;
        step(2);
        tick_chk("p_n1", 4'b0000);
        tick_chk("p_n2", 4'b0000);
        tick_chk("p_n3", 4'b0001);

        // Clear on road A, then a rising edge coinciding with clr_a while both roads rise together
        raw_a = 1'b0;
        step(2);
        tick_chk("c_f1", 4'b0001);
        tick_chk("c_f2", 4'b0001);
        tick_chk("c_f3", LATCH ? 4'b0001 : 4'b0000);
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        expect_now("a_clr", 4'b0000);
        step(2);
        raw_a = 1'b1;
        raw_b = 1'b1;
        step(2);
        tick_chk("d_t1", 4'b0000);
        tick_chk("d_t2", 4'b0000);
        clr_a = 1'b1;
        tick  = 1'b1;
        step();
        tick  = 1'b0;
        clr_a = 1'b0;
        expect_now("set_wins", 4'b0011);
        step();
        expect_now("set_hold", 4'b0011);
        step();

        for (int i = 0; i < 50 && q.size() > 0; i++) step();
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d checks still queued, required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
